// File: rtl/look_ahead_routing_vc.sv
// Look-ahead routing stage with per-VC wormhole route locking.
// A head flit computes the next-hop route and pins it to its VC;
// body/tail flits reuse the pinned route until the tail releases it.

package rvh_noc_pkg;
    localparam int unsigned NodeID_X_Width = 2;
    localparam int unsigned NodeID_Y_Width = 2;
    localparam int unsigned DevicePort_Width = 2;

    // Local ports occupy the upper half so L[n] = {1'b1, n}
    typedef enum logic [2:0] {
        N  = 3'd0,
        S  = 3'd1,
        E  = 3'd2,
        W  = 3'd3,
        L0 = 3'd4,
        L1 = 3'd5,
        L2 = 3'd6,
        L3 = 3'd7
    } io_port_t;

    typedef struct packed {
        io_port_t                    look_ahead_routing;
        logic [NodeID_X_Width-1:0]   tgt_id_x;
        logic [NodeID_Y_Width-1:0]   tgt_id_y;
        logic [DevicePort_Width-1:0] device_port;
        logic [7:0]                  payload;
    } flit_dec_t;
endpackage

module look_ahead_routing_vc
    import rvh_noc_pkg::*;
#(
    parameter int unsigned VC_NUM         = 4,
    parameter int unsigned LOCAL_PORT_NUM = 1,
    parameter int unsigned ROUTING_MODE   = 0,
    localparam int unsigned VC_ID_W       = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NodeID_X_Width-1:0] node_id_x_ths_hop_i,
    input  logic [NodeID_Y_Width-1:0] node_id_y_ths_hop_i,
    input  logic                      in_vld_i,
    output logic                      in_rdy_o,
    input  logic [VC_ID_W-1:0]        in_vc_id_i,
    input  logic                      in_head_i,
    input  logic                      in_tail_i,
    input  flit_dec_t                 in_flit_i,
    output logic                      out_vld_o,
    input  logic                      out_rdy_i,
    output logic [VC_ID_W-1:0]        out_vc_id_o,
    output flit_dec_t                 out_flit_o,
    output logic [VC_NUM-1:0]         vc_locked_o,
    output logic                      err_o,
    input  logic                      err_clr_i
);

    typedef enum logic {
        VC_IDLE,
        VC_LOCKED
    } vc_state_e;

    vc_state_e                 vc_state_q  [VC_NUM];
    vc_state_e                 vc_state_d  [VC_NUM];
    io_port_t                  route_tbl_q [VC_NUM];
    io_port_t                  route_tbl_d [VC_NUM];
    logic                      out_vld_q,   out_vld_d;
    logic [VC_ID_W-1:0]        out_vc_id_q, out_vc_id_d;
    flit_dec_t                 out_flit_q,  out_flit_d;
    logic                      err_q,       err_d;

    logic [NodeID_X_Width-1:0] nxt_x;
    logic [NodeID_Y_Width-1:0] nxt_y;
    logic                      wrap_err;
    logic                      local_err;
    io_port_t                  local_route;
    io_port_t                  ew_route;
    io_port_t                  ns_route;
    io_port_t                  calc_route;
    logic                      calc_err;
    logic                      accept;
    logic                      err_evt;

    assign in_rdy_o    = !out_vld_q || out_rdy_i;
    assign accept      = in_vld_i && in_rdy_o;
    assign out_vld_o   = out_vld_q;
    assign out_vc_id_o = out_vc_id_q;
    assign out_flit_o  = out_flit_q;
    assign err_o       = err_q;

    // Next-hop coordinates from the look-ahead port, flagging wrap-around
    always_comb begin
        nxt_x    = node_id_x_ths_hop_i;
        nxt_y    = node_id_y_ths_hop_i;
        wrap_err = 1'b0;
        case (in_flit_i.look_ahead_routing)
            N: begin
                nxt_y    = node_id_y_ths_hop_i + 1'b1;
                wrap_err = &node_id_y_ths_hop_i;
            end
            S: begin
                nxt_y    = node_id_y_ths_hop_i - 1'b1;
                wrap_err = ~|node_id_y_ths_hop_i;
            end
            E: begin
                nxt_x    = node_id_x_ths_hop_i + 1'b1;
                wrap_err = &node_id_x_ths_hop_i;
            end
            W: begin
                nxt_x    = node_id_x_ths_hop_i - 1'b1;
                wrap_err = ~|node_id_x_ths_hop_i;
            end
            default: ;
        endcase
    end

    // Dimension-ordered route selection at the next hop
    always_comb begin
        local_route = L0;
        local_err   = 1'b0;
        if (32'(in_flit_i.device_port) < LOCAL_PORT_NUM) begin
            local_route = io_port_t'({1'b1, in_flit_i.device_port});
        end else begin
            local_err = 1'b1;
        end

        ew_route = (nxt_x < in_flit_i.tgt_id_x) ? E : W;
        ns_route = (nxt_y < in_flit_i.tgt_id_y) ? N : S;

        calc_route = local_route;
        calc_err   = wrap_err;
        if (ROUTING_MODE == 0) begin
            if (nxt_x != in_flit_i.tgt_id_x) begin
                calc_route = ew_route;
            end else if (nxt_y != in_flit_i.tgt_id_y) begin
                calc_route = ns_route;
            end else begin
                calc_err = wrap_err | local_err;
            end
        end else begin
            if (nxt_y != in_flit_i.tgt_id_y) begin
                calc_route = ns_route;
            end else if (nxt_x != in_flit_i.tgt_id_x) begin
                calc_route = ew_route;
            end else begin
                calc_err = wrap_err | local_err;
            end
        end
    end

    // Per-VC lock state, route table, output register and sticky error
    always_comb begin
        vc_state_d  = vc_state_q;
        route_tbl_d = route_tbl_q;
        out_vld_d   = out_vld_q;
        out_vc_id_d = out_vc_id_q;
        out_flit_d  = out_flit_q;
        err_evt     = 1'b0;

        if (out_rdy_i) begin
            out_vld_d = 1'b0;
        end

        if (accept) begin
            out_vld_d   = 1'b1;
            out_vc_id_d = in_vc_id_i;
            out_flit_d  = in_flit_i;
            if (in_head_i) begin
                out_flit_d.look_ahead_routing = calc_route;
                route_tbl_d[in_vc_id_i]       = calc_route;
                err_evt = calc_err || (vc_state_q[in_vc_id_i] == VC_LOCKED);
                vc_state_d[in_vc_id_i] = in_tail_i ? VC_IDLE : VC_LOCKED;
            end else if (vc_state_q[in_vc_id_i] == VC_LOCKED) begin
                out_flit_d.look_ahead_routing = route_tbl_q[in_vc_id_i];
                if (in_tail_i) begin
                    vc_state_d[in_vc_id_i] = VC_IDLE;
                end
            end else begin
                out_flit_d.look_ahead_routing = calc_route;
                err_evt = 1'b1;
            end
        end

        // Set takes priority over clear
        err_d = err_q;
        if (err_clr_i) begin
            err_d = 1'b0;
        end
        if (err_evt) begin
            err_d = 1'b1;
        end
    end

    // Lock flags exported per VC
    always_comb begin
        vc_locked_o = '0;
        for (int unsigned i = 0; i < VC_NUM; i++) begin
            vc_locked_o[i] = (vc_state_q[i] == VC_LOCKED);
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < VC_NUM; i++) begin
                vc_state_q[i]  <= VC_IDLE;
                route_tbl_q[i] <= L0;
            end
            out_vld_q   <= 1'b0;
            out_vc_id_q <= '0;
            out_flit_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            vc_state_q  <= vc_state_d;
            route_tbl_q <= route_tbl_d;
            out_vld_q   <= out_vld_d;
            out_vc_id_q <= out_vc_id_d;
            out_flit_q  <= out_flit_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_look_ahead_routing_vc.sv
// Randomised and directed checks of look_ahead_routing_vc against a
// behavioural model; instance 0 routes XY, instance 1 routes YX.
module tb_look_ahead_routing_vc;
    import rvh_noc_pkg::*;

    localparam int VCN  = 4;
    localparam int LPN  = 2;
    localparam int XMAX = (1 << NodeID_X_Width) - 1;
    localparam int YMAX = (1 << NodeID_Y_Width) - 1;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NodeID_X_Width-1:0] node_x;
    logic [NodeID_Y_Width-1:0] node_y;
    logic                      in_vld;
    logic [1:0]                in_vc;
    logic                      in_head;
    logic                      in_tail;
    flit_dec_t                 in_flit;
    logic                      out_rdy;
    logic                      err_clr;

    logic       in_rdy [2];
    logic       o_vld  [2];
    logic [1:0] o_vc   [2];
    flit_dec_t  o_flit [2];
    logic [3:0] o_lock [2];
    logic       o_err  [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state per instance
    bit        m_vld  [2];
    int        m_vc   [2];
    flit_dec_t m_flit [2];
    bit        m_err  [2];
    bit        m_lock [2][VCN];
    io_port_t  m_tbl  [2][VCN];

    always #5 clk = ~clk;

    look_ahead_routing_vc #(.VC_NUM(VCN), .LOCAL_PORT_NUM(LPN), .ROUTING_MODE(0)) dut_xy (
        .clk(clk), .rst(rst),
        .node_id_x_ths_hop_i(node_x), .node_id_y_ths_hop_i(node_y),
        .in_vld_i(in_vld), .in_rdy_o(in_rdy[0]), .in_vc_id_i(in_vc),
        .in_head_i(in_head), .in_tail_i(in_tail), .in_flit_i(in_flit),
        .out_vld_o(o_vld[0]), .out_rdy_i(out_rdy), .out_vc_id_o(o_vc[0]),
        .out_flit_o(o_flit[0]), .vc_locked_o(o_lock[0]),
        .err_o(o_err[0]), .err_clr_i(err_clr)
    );

    look_ahead_routing_vc #(.VC_NUM(VCN), .LOCAL_PORT_NUM(LPN), .ROUTING_MODE(1)) dut_yx (
        .clk(clk), .rst(rst),
        .node_id_x_ths_hop_i(node_x), .node_id_y_ths_hop_i(node_y),
        .in_vld_i(in_vld), .in_rdy_o(in_rdy[1]), .in_vc_id_i(in_vc),
        .in_head_i(in_head), .in_tail_i(in_tail), .in_flit_i(in_flit),
        .out_vld_o(o_vld[1]), .out_rdy_i(out_rdy), .out_vc_id_o(o_vc[1]),
        .out_flit_o(o_flit[1]), .vc_locked_o(o_lock[1]),
        .err_o(o_err[1]), .err_clr_i(err_clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic flit_dec_t mk(input io_port_t lar, input int tx, input int ty,
                                     input int dp, input int pl);
        flit_dec_t f;
        f.look_ahead_routing = lar;
        f.tgt_id_x           = NodeID_X_Width'(tx);
        f.tgt_id_y           = NodeID_Y_Width'(ty);
        f.device_port        = DevicePort_Width'(dp);
        f.payload            = 8'(pl);
        return f;
    endfunction

    // Route rule stated directly: move one hop, then pick the first
    // differing dimension in the configured order, else the local port.
    function automatic io_port_t ref_route(input int mode, input int x, input int y,
                                           input flit_dec_t f, output bit err);
        io_port_t lports[4] = '{L0, L1, L2, L3};
        int nx = x;
        int ny = y;
        int dx = int'(f.tgt_id_x);
        int dy = int'(f.tgt_id_y);
        int dp = int'(f.device_port);
        err = 0;
        if (f.look_ahead_routing == N) begin
            if (y == YMAX) begin err = 1; ny = 0; end else ny = y + 1;
        end else if (f.look_ahead_routing == S) begin
            if (y == 0) begin err = 1; ny = YMAX; end else ny = y - 1;
        end else if (f.look_ahead_routing == E) begin
            if (x == XMAX) begin err = 1; nx = 0; end else nx = x + 1;
        end else if (f.look_ahead_routing == W) begin
            if (x == 0) begin err = 1; nx = XMAX; end else nx = x - 1;
        end
        if (mode == 0) begin
            if (nx != dx) return (nx < dx) ? E : W;
            if (ny != dy) return (ny < dy) ? N : S;
        end else begin
            if (ny != dy) return (ny < dy) ? N : S;
            if (nx != dx) return (nx < dx) ? E : W;
        end
        if (dp < LPN) return lports[dp];
        err = 1;
        return L0;
    endfunction

    task automatic check_outputs();
        logic [3:0] exp_lock;
        for (int i = 0; i < 2; i++) begin
            for (int v = 0; v < VCN; v++) exp_lock[v] = m_lock[i][v];
            check_eq($sformatf("out_vld%0d", i), 32'(o_vld[i]), 32'(m_vld[i]));
            check_eq($sformatf("err%0d", i), 32'(o_err[i]), 32'(m_err[i]));
            check_eq($sformatf("vc_locked%0d", i), 32'(o_lock[i]), 32'(exp_lock));
            if (m_vld[i]) begin
                check_eq($sformatf("out_vc%0d", i), 32'(o_vc[i]), 32'(m_vc[i]));
                check_eq($sformatf("out_flit%0d", i), 32'(o_flit[i]), 32'(m_flit[i]));
            end
        end
    endtask

    // One clock: drive, check ready and advance the model, then check outputs
    task automatic step(input bit vld, input int vc, input bit hd, input bit tl,
                        input flit_dec_t f, input bit ordy, input bit clr);
        bit        e;
        bit        evt;
        io_port_t  r;
        in_vld  = vld;
        in_vc   = 2'(vc);
        in_head = hd;
        in_tail = tl;
        in_flit = f;
        out_rdy = ordy;
        err_clr = clr;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            bit rdy = !m_vld[i] || ordy;
            check_eq($sformatf("in_rdy%0d", i), 32'(in_rdy[i]), 32'(rdy));
            evt = 0;
            if (ordy) m_vld[i] = 0;
            if (vld && rdy) begin
                m_vld[i]  = 1;
                m_vc[i]   = vc;
                m_flit[i] = f;
                if (hd) begin
                    r = ref_route(i, int'(node_x), int'(node_y), f, e);
                    evt = e || m_lock[i][vc];
                    m_tbl[i][vc]  = r;
                    m_lock[i][vc] = !tl;
                end else if (m_lock[i][vc]) begin
                    r = m_tbl[i][vc];
                    if (tl) m_lock[i][vc] = 0;
                end else begin
                    r = ref_route(i, int'(node_x), int'(node_y), f, e);
                    evt = 1;
                end
                m_flit[i].look_ahead_routing = r;
            end
            if (clr) m_err[i] = 0;
            if (evt) m_err[i] = 1;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, '0, 1, 0);
    endtask

    task automatic do_reset();
        in_vld  = 0;
        err_clr = 0;
        out_rdy = 1;
        in_head = 0;
        in_tail = 0;
        in_vc   = '0;
        in_flit = '0;
        rst     = 1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("rst_vld%0d", i), 32'(o_vld[i]), 0);
            check_eq($sformatf("rst_lock%0d", i), 32'(o_lock[i]), 0);
            check_eq($sformatf("rst_err%0d", i), 32'(o_err[i]), 0);
            check_eq($sformatf("rst_vc%0d", i), 32'(o_vc[i]), 0);
            check_eq($sformatf("rst_flit%0d", i), 32'(o_flit[i]), 0);
            m_vld[i] = 0;
            m_err[i] = 0;
            for (int v = 0; v < VCN; v++) begin
                m_lock[i][v] = 0;
                m_tbl[i][v]  = L0;
            end
        end
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        node_x = 2'd1;
        node_y = 2'd1;
        do_reset();

        // XY single hop east; both orders agree
        step(1, 0, 1, 1, mk(E, 3, 1, 0, 8'h11), 1, 0);
        check_eq("xy_route_e", 32'(o_flit[0].look_ahead_routing), 32'(E));
        check_eq("yx_route_e", 32'(o_flit[1].look_ahead_routing), 32'(E));

        // Diagonal destination separates XY from YX
        step(1, 1, 1, 1, mk(E, 3, 3, 0, 8'h22), 1, 0);
        check_eq("xy_diag_e", 32'(o_flit[0].look_ahead_routing), 32'(E));
        check_eq("yx_diag_n", 32'(o_flit[1].look_ahead_routing), 32'(N));

        // Local port selection and out-of-range port
        step(1, 0, 1, 1, mk(E, 2, 1, 1, 8'h33), 1, 0);
        check_eq("local_l1", 32'(o_flit[0].look_ahead_routing), 32'(L1));
        check_eq("local_l1_noerr", 32'(o_err[0]), 0);
        step(1, 0, 1, 1, mk(E, 2, 1, 3, 8'h44), 1, 0);
        check_eq("local_bad_l0", 32'(o_flit[0].look_ahead_routing), 32'(L0));
        check_eq("local_bad_err", 32'(o_err[0]), 1);
        step(0, 0, 0, 0, '0, 1, 1);
        check_eq("err_cleared", 32'(o_err[0]), 0);

        // Wormhole on VC2: body flits follow the head's route
        step(1, 2, 1, 0, mk(E, 3, 1, 0, 8'h50), 1, 0);
        check_eq("worm_head_lock", 32'(o_lock[0][2]), 1);
        step(1, 2, 0, 0, mk(E, 0, 0, 0, 8'h51), 1, 0);
        check_eq("worm_body1_e", 32'(o_flit[0].look_ahead_routing), 32'(E));
        step(1, 2, 0, 0, mk(E, 1, 3, 1, 8'h52), 1, 0);
        check_eq("worm_body2_e", 32'(o_flit[1].look_ahead_routing), 32'(E));
        step(1, 2, 0, 1, mk(W, 0, 2, 0, 8'h53), 1, 0);
        check_eq("worm_tail_unlock", 32'(o_lock[0][2]), 0);
        check_eq("worm_noerr", 32'(o_err[0]), 0);

        // Backpressure: output holds while the next flit waits
        step(1, 3, 1, 1, mk(N, 1, 3, 0, 8'hA0), 1, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 3, 1, 1, mk(S, 1, 0, 0, 8'hB0), 0, 0);
            check_eq("bp_held_payload", 32'(o_flit[0].payload), 32'h0A0);
        end
        step(1, 3, 1, 1, mk(S, 1, 0, 0, 8'hB0), 1, 0);
        check_eq("bp_next_payload", 32'(o_flit[0].payload), 32'h0B0);
        idle(1);

        // Wrap-around going east from the last column
        node_x = 2'd3;
        step(1, 0, 1, 1, mk(E, 0, 1, 0, 8'hC0), 1, 0);
        check_eq("wrap_err", 32'(o_err[0]), 1);
        step(0, 0, 0, 0, '0, 1, 1);
        node_x = 2'd1;

        // Reset in the middle of a packet on VC1
        step(1, 1, 1, 0, mk(E, 3, 1, 0, 8'hD0), 1, 0);
        check_eq("mid_lock_vc1", 32'(o_lock[0][1]), 1);
        do_reset();
        step(1, 1, 0, 0, mk(E, 3, 1, 0, 8'hD1), 1, 0);
        check_eq("post_rst_body_err", 32'(o_err[0]), 1);
        step(0, 0, 0, 0, '0, 1, 1);

        // Randomised traffic
        for (int c = 0; c < 800; c++) begin
            flit_dec_t f;
            if (c % 64 == 0) begin
                node_x = NodeID_X_Width'($urandom_range(0, XMAX));
                node_y = NodeID_Y_Width'($urandom_range(0, YMAX));
            end
            f = mk(io_port_t'($urandom_range(0, 7)), $urandom_range(0, XMAX),
                   $urandom_range(0, YMAX), $urandom_range(0, 3), $urandom_range(0, 255));
            step($urandom_range(0, 3) != 0, $urandom_range(0, VCN - 1),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, f,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
